// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - HD44780 bus owner: power-up init, then round-robin character writes from two requesters
//
// Optional feature macro: LCD_ARB_CLEAR_EN (adds clr_req/clr_ack, a clear-display request with priority in IDLE).
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   req0/line0/col0/char0    requester 0 level request and payload (row, column, character)
//   ack0                     requester 0 one-cycle completion pulse
//   req1/line1/col1/char1    requester 1, same as requester 0
//   ack1                     requester 1 one-cycle completion pulse
//   clr_req, clr_ack         (LCD_ARB_CLEAR_EN only) clear-display request / completion pulse
//   busy                     high whenever the FSM is not in IDLE
//   init_done                sticky once the power-up sequence has finished
//   LCD_DATA, LCD_E, LCD_RS  LCD bus: data, enable strobe, register select (0=cmd, 1=data)
//   LCD_RW                   tied low, the bus is write-only
module lcd_write_arbiter #(
  parameter int E_PULSE_CYC  = 20,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       line0,
  input  logic [3:0] col0,
  input  logic [7:0] char0,
  output logic       ack0,
  input  logic       req1,
  input  logic       line1,
  input  logic [3:0] col1,
  input  logic [7:0] char1,
  output logic       ack1,
`ifdef LCD_ARB_CLEAR_EN
  input  logic       clr_req,
  output logic       clr_ack,
`endif
  output logic       busy,
  output logic       init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  localparam int MAX_A   = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_CNT = (MAX_A > CLR_WAIT_CYC) ? MAX_A : CLR_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [3:0] {
    S_INIT_FS, S_INIT_ON, S_INIT_EM, S_INIT_CLR,
    S_IDLE, S_SET_ADDR, S_WR_CHAR, S_ACK, S_CLR_CMD
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_SETTLE} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last1_q, last1_d;   // 1: requester 1 was served last
  logic             gnt1_q, gnt1_d;     // requester owning the current transaction
  logic             line_q, line_d;
  logic [3:0]       col_q, col_d;
  logic [7:0]       char_q, char_d;
  logic             init_done_q, init_done_d;
`ifdef LCD_ARB_CLEAR_EN
  logic             clr_q, clr_d;       // current transaction is a clear, not a char write
`endif

  logic       is_bus;
  logic       long_wait;
  logic [7:0] bus_data;
  logic       grant0, grant1;

  // requester 0 wins a tie only when requester 1 was served last
  assign grant0 = req0 && (!req1 || last1_q);
  assign grant1 = req1 && !grant0;

  // What the current state puts on the bus; only clear-display needs the long settle.
  always_comb begin
    is_bus    = 1'b1;
    long_wait = 1'b0;
    bus_data  = 8'h00;
    case (state_q)
      S_INIT_FS:  bus_data = 8'h38;
      S_INIT_ON:  bus_data = 8'h0C;
      S_INIT_EM:  bus_data = 8'h06;
      S_INIT_CLR: begin bus_data = 8'h01; long_wait = 1'b1; end
      S_SET_ADDR: bus_data = {1'b1, line_q, 2'b00, col_q};
      S_WR_CHAR:  bus_data = char_q;
`ifdef LCD_ARB_CLEAR_EN
      S_CLR_CMD:  begin bus_data = 8'h01; long_wait = 1'b1; end
`endif
      default:    is_bus = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT_FS;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      last1_q     <= 1'b1;
      gnt1_q      <= 1'b0;
      line_q      <= 1'b0;
      col_q       <= 4'h0;
      char_q      <= 8'h00;
      init_done_q <= 1'b0;
`ifdef LCD_ARB_CLEAR_EN
      clr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      last1_q     <= last1_d;
      gnt1_q      <= gnt1_d;
      line_q      <= line_d;
      col_q       <= col_d;
      char_q      <= char_d;
      init_done_q <= init_done_d;
`ifdef LCD_ARB_CLEAR_EN
      clr_q       <= clr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    last1_d     = last1_q;
    gnt1_d      = gnt1_q;
    line_d      = line_q;
    col_d       = col_q;
    char_d      = char_q;
    init_done_d = init_done_q;
`ifdef LCD_ARB_CLEAR_EN
    clr_d       = clr_q;
`endif
    if (is_bus) begin
      // setup (1) -> strobe (E_PULSE_CYC) -> settle (wait), counter reloaded at each boundary
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_STROBE;
          cnt_d   = CNT_W'(E_PULSE_CYC - 1);
        end
        PH_STROBE: begin
          if (cnt_q == '0) begin
            phase_d = PH_SETTLE;
            cnt_d   = long_wait ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          if (cnt_q == '0) begin
            phase_d = PH_SETUP;
            case (state_q)
              S_INIT_FS:  state_d = S_INIT_ON;
              S_INIT_ON:  state_d = S_INIT_EM;
              S_INIT_EM:  state_d = S_INIT_CLR;
              S_INIT_CLR: begin state_d = S_IDLE; init_done_d = 1'b1; end
              S_SET_ADDR: state_d = S_WR_CHAR;
              default:    state_d = S_ACK;
            endcase
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      endcase
    end else if (state_q == S_IDLE) begin
      phase_d = PH_SETUP;
`ifdef LCD_ARB_CLEAR_EN
      // clears take priority and leave the round-robin pointer alone
      if (clr_req) begin
        state_d = S_CLR_CMD;
        clr_d   = 1'b1;
      end else
`endif
      if (grant0 || grant1) begin
        state_d = S_SET_ADDR;
        gnt1_d  = grant1;
        last1_d = grant1;
        line_d  = grant1 ? line1 : line0;
        col_d   = grant1 ? col1 : col0;
        char_d  = grant1 ? char1 : char0;
`ifdef LCD_ARB_CLEAR_EN
        clr_d   = 1'b0;
`endif
      end
    end else begin
      state_d = S_IDLE;
      phase_d = PH_SETUP;
    end
  end

  // Outputs are forced quiet while rst is held so nothing reaches the pins mid-reset.
  logic ack_pulse;
  assign ack_pulse = !rst && (state_q == S_ACK);

`ifdef LCD_ARB_CLEAR_EN
  assign ack0    = ack_pulse && !clr_q && !gnt1_q;
  assign ack1    = ack_pulse && !clr_q && gnt1_q;
  assign clr_ack = ack_pulse && clr_q;
`else
  assign ack0    = ack_pulse && !gnt1_q;
  assign ack1    = ack_pulse && gnt1_q;
`endif

  assign busy      = rst || (state_q != S_IDLE);
  assign init_done = init_done_q;
  assign LCD_DATA  = rst ? 8'h00 : bus_data;
  assign LCD_E     = !rst && is_bus && (phase_q == PH_STROBE);
  assign LCD_RS    = !rst && (state_q == S_WR_CHAR);
  assign LCD_RW    = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - self-checking bench for lcd_write_arbiter with bus-write scoreboard
module tb_lcd_write_arbiter;
  localparam int EP = 2;
  localparam int CW = 4;
  localparam int LW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, line0 = 1'b0, req1 = 1'b0, line1 = 1'b0;
  logic [3:0] col0 = 4'h0, col1 = 4'h0;
  logic [7:0] char0 = 8'h00, char1 = 8'h00;
  logic       ack0, ack1, busy, init_done, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;
`ifdef LCD_ARB_CLEAR_EN
  logic       clr_req = 1'b0;
  logic       clr_ack;
`endif

  always #5 clk = ~clk;

  lcd_write_arbiter #(.E_PULSE_CYC(EP), .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(LW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .line0(line0), .col0(col0), .char0(char0), .ack0(ack0),
    .req1(req1), .line1(line1), .col1(col1), .char1(char1), .ack1(ack1),
`ifdef LCD_ARB_CLEAR_EN
    .clr_req(clr_req), .clr_ack(clr_ack),
`endif
    .busy(busy), .init_done(init_done),
    .LCD_DATA(LCD_DATA), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic rs; logic [7:0] data;} wr_t;
  wr_t exp_q[$];

  // Bus monitor: captures each E pulse and compares it against the scoreboard when E falls.
  logic       in_str = 1'b0, bad = 1'b0, cap_rs = 1'b0, prev_rs = 1'b0;
  logic [7:0] cap_data = 8'h00, prev_data = 8'h00;
  int         e_len = 0;
  wr_t        w;

  always @(negedge clk) begin
    if (rst) begin
      in_str = 1'b0;
      e_len  = 0;
    end else if (LCD_E) begin
      if (!in_str) begin
        in_str   = 1'b1;
        e_len    = 1;
        cap_rs   = LCD_RS;
        cap_data = LCD_DATA;
        bad      = (prev_rs !== LCD_RS) || (prev_data !== LCD_DATA);
      end else begin
        e_len++;
        if (LCD_RS !== cap_rs || LCD_DATA !== cap_data) bad = 1'b1;
      end
    end else if (in_str) begin
      in_str = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rs=%0d data=%0h expected no write", cap_rs, cap_data);
      end else begin
        w = exp_q.pop_front();
        check("bus_rs", 32'(cap_rs), 32'(w.rs));
        check("bus_data", 32'(cap_data), 32'(w.data));
        check("e_width", e_len, EP);
        check("setup_strobe_stable", 32'(bad), 0);
        check("lcd_rw", 32'(LCD_RW), 0);
      end
    end
    prev_rs   = LCD_RS;
    prev_data = LCD_DATA;
  end

  function automatic logic ack_of(input bit who);
    return who ? ack1 : ack0;
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  typedef struct {bit who; bit line; bit [3:0] col; bit [7:0] chr; bit [7:0] exp_addr;} vec_t;
  vec_t tbl[4];

  initial begin
    int     lat, n, n0, n1;
    bit     seen, other, both, saw_ack;
    bit [3:0] ord;

    tbl[0] = '{who: 1'b0, line: 1'b0, col: 4'd5,  chr: 8'h41, exp_addr: 8'h85};
    tbl[1] = '{who: 1'b1, line: 1'b1, col: 4'd15, chr: 8'h42, exp_addr: 8'hCF};
    tbl[2] = '{who: 1'b0, line: 1'b1, col: 4'd0,  chr: 8'h30, exp_addr: 8'hC0};
    tbl[3] = '{who: 1'b1, line: 1'b0, col: 4'd10, chr: 8'h7E, exp_addr: 8'h8A};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 1);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_lcd_e", 32'(LCD_E), 0);
    check("rst_lcd_data", 32'(LCD_DATA), 0);
    check("rst_lcd_rs", 32'(LCD_RS), 0);
    check("rst_acks", 32'({ack1, ack0}), 0);

    // init sequence and its duration
    push_init();
    rst = 1'b0;
    lat = 0;
    while (!init_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("init_done_latency", lat, 32);
    check("init_queue_drained", exp_q.size(), 0);
    check("idle_busy", 32'(busy), 0);

    // single writes from the table
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!tbl[i].who) begin
        req0 = 1'b1; line0 = tbl[i].line; col0 = tbl[i].col; char0 = tbl[i].chr;
      end else begin
        req1 = 1'b1; line1 = tbl[i].line; col1 = tbl[i].col; char1 = tbl[i].chr;
      end
      exp_q.push_back({1'b0, tbl[i].exp_addr});
      exp_q.push_back({1'b1, tbl[i].chr});
      lat = 0; seen = 1'b0; other = 1'b0;
      while (!seen && lat < 100) begin
        @(negedge clk);
        lat++;
        if (ack_of(!tbl[i].who)) other = 1'b1;
        if (ack_of(tbl[i].who)) begin
          seen = 1'b1;
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      check($sformatf("vec%0d_ack_latency", i), lat, 15);
      check($sformatf("vec%0d_other_ack", i), 32'(other), 0);
      @(negedge clk);
      check($sformatf("vec%0d_ack_single", i), 32'(ack_of(tbl[i].who)), 0);
    end

    // contention: both held; grants alternate 0,1,0,1
    @(negedge clk);
    req0 = 1'b1; line0 = 1'b0; col0 = 4'd5;  char0 = 8'h41;
    req1 = 1'b1; line1 = 1'b1; col1 = 4'd15; char1 = 8'h42;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, 8'h85}); exp_q.push_back({1'b1, 8'h41});
      exp_q.push_back({1'b0, 8'hCF}); exp_q.push_back({1'b1, 8'h42});
    end
    n = 0; n0 = 0; n1 = 0; lat = 0; both = 1'b0; ord = 4'b1111;
    while (n < 4 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (ack0 && ack1) both = 1'b1;
      if (ack0) begin
        ord[n] = 1'b0; n++; n0++;
        if (n0 == 2) req0 = 1'b0;
      end else if (ack1) begin
        ord[n] = 1'b1; n++; n1++;
        if (n1 == 2) req1 = 1'b0;
      end
    end
    check("contend_count", n, 4);
    check("contend_order", 32'(ord), 32'(4'b1010));
    check("contend_both_acks", 32'(both), 0);

    // abandoned request: one-cycle req1, payload changed afterwards
    @(negedge clk);
    @(negedge clk);
    req1 = 1'b1; line1 = 1'b0; col1 = 4'd3; char1 = 8'h55;
    exp_q.push_back({1'b0, 8'h83});
    exp_q.push_back({1'b1, 8'h55});
    @(negedge clk);
    req1 = 1'b0; line1 = 1'b1; col1 = 4'd9; char1 = 8'h99;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (ack1) seen = 1'b1;
    end
    check("abandon_ack_latency", lat, 15);

`ifdef LCD_ARB_CLEAR_EN
    // clear request beats a simultaneous req0
    @(negedge clk);
    @(negedge clk);
    clr_req = 1'b1;
    req0 = 1'b1; line0 = 1'b0; col0 = 4'd0; char0 = 8'h20;
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, 8'h20});
    lat = 0; seen = 1'b0; other = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (ack0) other = 1'b1;
      if (clr_ack) begin seen = 1'b1; clr_req = 1'b0; end
    end
    check("clr_ack_latency", lat, 12);
    check("clr_before_req0", 32'(other), 0);
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (ack0) begin seen = 1'b1; req0 = 1'b0; end
    end
    check("req0_after_clr_latency", lat, 28);
`endif

    // reset during the WR_CHAR strobe
    @(negedge clk);
    @(negedge clk);
    req0 = 1'b1; line0 = 1'b1; col0 = 4'd2; char0 = 8'h61;
    exp_q.push_back({1'b0, 8'hC2});
    lat = 0;
    while (!(LCD_E && LCD_RS) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("wr_char_strobe_reached", 32'(LCD_E && LCD_RS), 1);
    rst = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_lcd_e", 32'(LCD_E), 0);
    check("midrst_busy", 32'(busy), 1);
    check("midrst_init_done", 32'(init_done), 0);
    check("midrst_ack0", 32'(ack0), 0);
    push_init();
    rst = 1'b0;
    lat = 0; saw_ack = 1'b0;
    while (!init_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack0 || ack1) saw_ack = 1'b1;
    end
    check("reinit_latency", lat, 32);
    check("midrst_no_ack", 32'(saw_ack), 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
